// File: rtl/rx_data_sampler_if.sv
// rx_data_sampler_if - bus between the UART RX control FSM and the
// oversampling front end. The FSM side drives the serial line, the
// oversampling ratio and the enable, and observes the counters,
// the voted bit and the strobes. The sampler side is the reverse.
interface rx_data_sampler_if #(
    parameter int PRESCALE_WIDTH = 6,
    parameter int CNT_WIDTH      = 4
);
    logic                      RX_IN;
    logic [PRESCALE_WIDTH-1:0] PRESCALE;
    logic                      smp_en;
    logic [PRESCALE_WIDTH-1:0] edge_cnt;
    logic [CNT_WIDTH-1:0]      bit_cnt;
    logic                      sampled_bit;
    logic                      sample_vld;
    logic                      frame_done;

    modport master (
        output RX_IN,
        output PRESCALE,
        output smp_en,
        input  edge_cnt,
        input  bit_cnt,
        input  sampled_bit,
        input  sample_vld,
        input  frame_done
    );

    modport slave (
        input  RX_IN,
        input  PRESCALE,
        input  smp_en,
        output edge_cnt,
        output bit_cnt,
        output sampled_bit,
        output sample_vld,
        output frame_done
    );
endinterface

// File: rtl/rx_data_sampler.sv
// rx_data_sampler - oversampling front end of the UART receiver.
// Counts prescaled clock edges within each bit period, votes on the
// serial line around mid-bit and presents one sampled bit per period
// with a one-cycle strobe. Also tracks the bit index within the frame
// and pulses frame_done once the last bit period has ended.
//
// Build option: define RX_SAMPLER_MAJ3_EN for a three-sample majority
// vote around mid-bit. Without it the bit is taken from the single
// sample captured exactly at mid-bit. The strobe lands on the same
// cycle in both builds, so downstream timing does not change.
module rx_data_sampler #(
    parameter int PRESCALE_WIDTH = 6,
    parameter int FRAME_BITS     = 11,
    parameter int CNT_WIDTH      = 4
) (
    input  logic             CLK,
    input  logic             RST,
    rx_data_sampler_if.slave bus
);

    localparam logic [CNT_WIDTH-1:0]      LAST_BIT = CNT_WIDTH'(FRAME_BITS - 1);
    localparam logic [CNT_WIDTH-1:0]      BIT_ONE  = CNT_WIDTH'(1);
    localparam logic [PRESCALE_WIDTH-1:0] EDGE_ONE = PRESCALE_WIDTH'(1);

    // Positions within the bit period, all derived from PRESCALE at
    // full counter width.
    logic [PRESCALE_WIDTH-1:0] w_mid;
    logic [PRESCALE_WIDTH-1:0] w_midNext;
    logic [PRESCALE_WIDTH-1:0] w_lastEdge;
    logic                      w_edgeWrap;
    logic                      w_lastBit;
    logic                      w_voteNow;
    logic                      w_voteBit;

    logic [PRESCALE_WIDTH-1:0] r_edgeCnt;
    logic [CNT_WIDTH-1:0]      r_bitCnt;
    logic                      r_smpMid;
    logic                      r_sampledBit;
    logic                      r_sampleVld;
    logic                      r_frameDone;

`ifdef RX_SAMPLER_MAJ3_EN
    logic [PRESCALE_WIDTH-1:0] w_midPrev;
    logic                      r_smpEarly;
`endif

    assign w_mid      = bus.PRESCALE >> 1;
    assign w_midNext  = w_mid + EDGE_ONE;
    assign w_lastEdge = bus.PRESCALE - EDGE_ONE;

    // The wrap test uses >= rather than == so that a counter left
    // beyond the last edge by an illegal mid-frame PRESCALE change
    // wraps on the next cycle instead of running round the full range.
    assign w_edgeWrap = (r_edgeCnt >= w_lastEdge);
    assign w_lastBit  = (r_bitCnt >= LAST_BIT);
    assign w_voteNow  = bus.smp_en && (r_edgeCnt == w_midNext);

`ifdef RX_SAMPLER_MAJ3_EN
    assign w_midPrev = w_mid - EDGE_ONE;

    // The third vote sample is the live line on the vote edge itself,
    // which is the same instant the MID+1 capture would occur, so the
    // vote does not need to wait a further cycle for a late flop.
    assign w_voteBit = (r_smpEarly & r_smpMid)
                     | (r_smpEarly & bus.RX_IN)
                     | (r_smpMid   & bus.RX_IN);
`else
    assign w_voteBit = r_smpMid;
`endif

    // Edge and bit counters: cleared while disabled so that a fresh
    // enable always starts at edge 0 of bit 0; bit counter advances
    // on each edge wrap and folds back to 0 after the last frame bit.
    always_ff @(posedge CLK) begin
        if (RST || !bus.smp_en) begin
            r_edgeCnt <= '0;
            r_bitCnt  <= '0;
        end else if (w_edgeWrap) begin
            r_edgeCnt <= '0;
            r_bitCnt  <= w_lastBit ? '0 : (r_bitCnt + BIT_ONE);
        end else begin
            r_edgeCnt <= r_edgeCnt + EDGE_ONE;
        end
    end

    // Mid-bit capture flops, cleared whenever sampling is disabled.
    always_ff @(posedge CLK) begin
        if (RST || !bus.smp_en) begin
            r_smpMid <= 1'b0;
        end else if (r_edgeCnt == w_mid) begin
            r_smpMid <= bus.RX_IN;
        end
    end

`ifdef RX_SAMPLER_MAJ3_EN
    // Early capture one edge before mid-bit, feeding the majority vote.
    always_ff @(posedge CLK) begin
        if (RST || !bus.smp_en) begin
            r_smpEarly <= 1'b0;
        end else if (r_edgeCnt == w_midPrev) begin
            r_smpEarly <= bus.RX_IN;
        end
    end
`endif

    // Vote register and strobe: load the new bit on the MID+1 edge and
    // raise the strobe for the following cycle; the bit holds between
    // strobes and across disable, and resets to the idle-line level.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sampledBit <= 1'b1;
            r_sampleVld  <= 1'b0;
        end else if (w_voteNow) begin
            r_sampledBit <= w_voteBit;
            r_sampleVld  <= 1'b1;
        end else begin
            r_sampleVld  <= 1'b0;
        end
    end

    // Frame completion: one-cycle pulse after the final edge of the
    // last bit period, only if sampling was enabled on that edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_frameDone <= 1'b0;
        end else begin
            r_frameDone <= bus.smp_en && w_edgeWrap && w_lastBit;
        end
    end

    assign bus.edge_cnt    = r_edgeCnt;
    assign bus.bit_cnt     = r_bitCnt;
    assign bus.sampled_bit = r_sampledBit;
    assign bus.sample_vld  = r_sampleVld;
    assign bus.frame_done  = r_frameDone;

endmodule

// File: tb/tb_rx_data_sampler.sv
// tb_rx_data_sampler - directed self-checking bench for rx_data_sampler.
// Expected values are hand-derived from the bit-period timing: after
// n enabled clock edges edge_cnt = n mod PRESCALE, bit_cnt =
// (n / PRESCALE) mod 11, and the strobe is visible when edge_cnt =
// PRESCALE/2 + 2. Expectations that differ between the majority and
// single-sample builds follow RX_SAMPLER_MAJ3_EN.
module tb_rx_data_sampler;

    logic CLK;
    logic RST;

    int checks;
    int errors;
    int vldCount;
    int doneCount;
    int t;
    logic [10:0] frame;

`ifdef RX_SAMPLER_MAJ3_EN
    localparam logic GLITCH_EXP = 1'b1;
    localparam logic WINDOW_EXP = 1'b0;
`else
    localparam logic GLITCH_EXP = 1'b0;
    localparam logic WINDOW_EXP = 1'b1;
`endif

    rx_data_sampler_if #(.PRESCALE_WIDTH(6), .CNT_WIDTH(4)) bus ();

    rx_data_sampler #(
        .PRESCALE_WIDTH(6),
        .FRAME_BITS    (11),
        .CNT_WIDTH     (4)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    // Free-running 10 ns clock.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drive the inputs for the coming edge, then advance past it.
    task automatic applyStimulus(input logic rx, input logic en, input logic rst);
        bus.RX_IN  = rx;
        bus.smp_en = en;
        RST        = rst;
        @(posedge CLK);
        #1;
    endtask

    // One comparison: count it, and report any difference.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Check the full output set against reset values.
    task automatic checkIdle(input string tag, input logic expBit);
        checkOutput({tag, " edge_cnt"},    32'(bus.edge_cnt),    32'd0);
        checkOutput({tag, " bit_cnt"},     32'(bus.bit_cnt),     32'd0);
        checkOutput({tag, " sample_vld"},  32'(bus.sample_vld),  32'd0);
        checkOutput({tag, " frame_done"},  32'(bus.frame_done),  32'd0);
        checkOutput({tag, " sampled_bit"}, 32'(bus.sampled_bit), 32'(expBit));
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        bus.RX_IN    = 1'b1;
        bus.smp_en   = 1'b0;
        bus.PRESCALE = 6'd8;
        RST          = 1'b1;

        // Reset
        $display("[TB] reset");
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkIdle("reset", 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);

        // Clean frame, PRESCALE=8, 0xA5 with even parity and stop
        $display("[TB] clean frame");
        frame     = {1'b1, 1'b0, 8'hA5, 1'b0};
        vldCount  = 0;
        doneCount = 0;
        for (int c = 0; c < 88; c++) begin
            applyStimulus(frame[c / 8], 1'b1, 1'b0);
            t = c + 1;
            checkOutput("clean edge_cnt",   32'(bus.edge_cnt),   32'(t % 8));
            checkOutput("clean bit_cnt",    32'(bus.bit_cnt),    32'((t / 8) % 11));
            checkOutput("clean sample_vld", 32'(bus.sample_vld), 32'(t % 8 == 6));
            checkOutput("clean frame_done", 32'(bus.frame_done), 32'(t == 88));
            if (t % 8 == 6)
                checkOutput("clean sampled_bit", 32'(bus.sampled_bit), 32'(frame[t / 8]));
            if (bus.sample_vld) vldCount++;
            if (bus.frame_done) doneCount++;
        end
        checkOutput("clean strobe count", 32'(vldCount),  32'd11);
        checkOutput("clean done count",   32'(doneCount), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkIdle("clean disabled", 1'b1);

        // Glitch rejection, PRESCALE=16, single low cycle at edge 8
        $display("[TB] glitch");
        bus.PRESCALE = 6'd16;
        for (int c = 0; c < 16; c++) begin
            applyStimulus((c == 8) ? 1'b0 : 1'b1, 1'b1, 1'b0);
            t = c + 1;
            checkOutput("glitch sample_vld", 32'(bus.sample_vld), 32'(t == 10));
            if (t == 10)
                checkOutput("glitch sampled_bit", 32'(bus.sampled_bit), 32'(GLITCH_EXP));
        end
        applyStimulus(1'b1, 1'b0, 1'b0);

        // Window boundaries, PRESCALE=32, low at 15 and 17
        $display("[TB] window inside");
        bus.PRESCALE = 6'd32;
        for (int c = 0; c < 32; c++) begin
            applyStimulus((c == 15 || c == 17) ? 1'b0 : 1'b1, 1'b1, 1'b0);
            t = c + 1;
            if (t == 18) begin
                checkOutput("window-in sample_vld",  32'(bus.sample_vld),  32'd1);
                checkOutput("window-in sampled_bit", 32'(bus.sampled_bit), 32'(WINDOW_EXP));
            end
        end
        applyStimulus(1'b1, 1'b0, 1'b0);

        // Window boundaries, PRESCALE=32, low at 14 and 18 (outside)
        $display("[TB] window outside");
        for (int c = 0; c < 32; c++) begin
            applyStimulus((c == 14 || c == 18) ? 1'b0 : 1'b1, 1'b1, 1'b0);
            t = c + 1;
            if (t == 18) begin
                checkOutput("window-out sample_vld",  32'(bus.sample_vld),  32'd1);
                checkOutput("window-out sampled_bit", 32'(bus.sampled_bit), 32'd1);
            end
        end
        applyStimulus(1'b1, 1'b0, 1'b0);

        // Abort, PRESCALE=8, drop enable at bit 3 edge 5
        $display("[TB] abort");
        bus.PRESCALE = 6'd8;
        for (int c = 0; c < 29; c++)
            applyStimulus((c / 8 == 1 || c / 8 == 3) ? 1'b1 : 1'b0, 1'b1, 1'b0);
        checkOutput("abort pre edge_cnt",    32'(bus.edge_cnt),    32'd5);
        checkOutput("abort pre bit_cnt",     32'(bus.bit_cnt),     32'd3);
        checkOutput("abort pre sampled_bit", 32'(bus.sampled_bit), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkIdle("abort", 1'b0);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkIdle("abort hold", 1'b0);
        end

        // Reset pulse mid-frame at bit 7
        $display("[TB] reset mid-frame");
        for (int c = 0; c < 58; c++)
            applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("midreset pre bit_cnt",     32'(bus.bit_cnt),     32'd7);
        checkOutput("midreset pre sampled_bit", 32'(bus.sampled_bit), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkIdle("midreset", 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("midreset restart edge_cnt", 32'(bus.edge_cnt), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0);

        // Back-to-back frames, PRESCALE=16, alternating bit values
        $display("[TB] back-to-back");
        bus.PRESCALE = 6'd16;
        vldCount  = 0;
        doneCount = 0;
        for (int c = 0; c < 352; c++) begin
            applyStimulus(((c / 16) % 11) % 2 == 1, 1'b1, 1'b0);
            t = c + 1;
            checkOutput("b2b edge_cnt",   32'(bus.edge_cnt),   32'(t % 16));
            checkOutput("b2b bit_cnt",    32'(bus.bit_cnt),    32'((t / 16) % 11));
            checkOutput("b2b sample_vld", 32'(bus.sample_vld), 32'(t % 16 == 10));
            checkOutput("b2b frame_done", 32'(bus.frame_done), 32'(t == 176 || t == 352));
            if (t % 16 == 10)
                checkOutput("b2b sampled_bit", 32'(bus.sampled_bit), 32'(((t / 16) % 11) % 2));
            if (bus.sample_vld) vldCount++;
            if (bus.frame_done) doneCount++;
        end
        checkOutput("b2b strobe count", 32'(vldCount),  32'd22);
        checkOutput("b2b done count",   32'(doneCount), 32'd2);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkIdle("b2b disabled", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_data_sampler.md
# rx_data_sampler

Oversampling front end of the UART receiver. It counts prescaled clock edges within each bit period and votes on the serial line around mid-bit. It presents one `sampled_bit` per bit period with a one-cycle `sample_vld` strobe. It feeds `sampled_bit` to the start/parity/stop check stages and exposes its bit and edge counters to the RX control FSM.

## Interface
- `PRESCALE_WIDTH`, default 6: width of the `PRESCALE` input and of `edge_cnt`.
- `FRAME_BITS`, default 11: bits per frame (start + 8 data + parity + stop); sets the `bit_cnt` wrap point.
- `CNT_WIDTH`, default 4: width of `bit_cnt`; must satisfy 2^CNT_WIDTH ≥ FRAME_BITS.

Ports:
- `CLK` input 1: single clock; all logic on the rising edge.
- `RST` input 1: synchronous, active-high reset.
- `RX_IN` input 1: serial line, already synchronised to `CLK`; idle high.
- `PRESCALE` input PRESCALE_WIDTH: oversampling ratio. Legal values are even numbers from 6 to 32; 8, 16 and 32 are the supported operating points.
- `smp_en` input 1: enables counting and sampling; driven by the RX FSM.
- `edge_cnt` output PRESCALE_WIDTH: position within the current bit, 0..PRESCALE-1.
- `bit_cnt` output CNT_WIDTH: index of the current bit within the frame, 0..FRAME_BITS-1.
- `sampled_bit` output 1: most recent voted bit value.
- `sample_vld` output 1: one-cycle strobe; `sampled_bit` is new on this cycle.
- `frame_done` output 1: one-cycle strobe when the last bit period of a frame ends.

## Operation
- The mid-bit point is `MID = PRESCALE >> 1`.
- Edge counter:
  - While `smp_en`=1, `edge_cnt` increments every cycle.
  - When `edge_cnt` = PRESCALE-1 it wraps to 0 and `bit_cnt` increments.
- Bit counter:
  - When `bit_cnt` = FRAME_BITS-1 and `edge_cnt` wraps, `bit_cnt` returns to 0.
  - `frame_done` pulses for one cycle on the following cycle.
- Capture window: three sample flops capture `RX_IN` when `edge_cnt` = MID-1, MID and MID+1.
- Vote:
  - On the clock edge where `edge_cnt` = MID+1, `sampled_bit` is loaded with the majority of the three samples, using `RX_IN` directly as the third sample.
  - `sample_vld` asserts for exactly that following cycle.
  - There is exactly one `sample_vld` per bit period.
- Between strobes, `sampled_bit` holds its value.
- Disable: while `smp_en`=0, `edge_cnt`, `bit_cnt` and the sample flops clear to 0 on the next edge. `sample_vld` and `frame_done` are 0. `sampled_bit` holds.
- Re-enable: when `smp_en` rises, counting starts from `edge_cnt`=0 and `bit_cnt`=0 on that same cycle.
- Dropping `smp_en` mid-frame (for example on a start glitch) aborts the frame: no `frame_done`, and the counters clear.
- `PRESCALE` may change only while `smp_en`=0. Behaviour for an illegal or mid-frame change is undefined but must not lock up; the next `smp_en`=0 cycle recovers.
- Arithmetic:
  - Counters are unsigned.
  - MID+1 ≤ PRESCALE-1 is guaranteed by PRESCALE ≥ 6.
  - The `edge_cnt` compare uses the full PRESCALE_WIDTH bits.

## Timing
- Reset values: `edge_cnt`=0, `bit_cnt`=0, `sampled_bit`=1 (idle line), `sample_vld`=0, `frame_done`=0, sample flops=0.
- `RST` has priority over `smp_en`.
- Reset asserted mid-frame clears everything on the next edge.
- `sampled_bit` and `sample_vld` change in the cycle where `edge_cnt` = MID+2. The latency from the last capture point is 1 cycle.
- With PRESCALE=8: samples are taken at `edge_cnt` 3, 4 and 5, and `sample_vld` is high while `edge_cnt`=6.
- `frame_done` is high in the cycle where `edge_cnt`=0 and `bit_cnt`=0 of the next frame, if `smp_en` is still 1. It still fires if `smp_en` falls on that same wrap edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro `RX_SAMPLER_MAJ3_EN`.
- Defined: three-sample majority vote as described above.
- Undefined:
  - Single-sample mode; `sampled_bit` is loaded from the value captured at `edge_cnt` = MID.
  - The MID-1 and MID+1 sample flops are not built.
  - The strobe position stays the same (`sample_vld` while `edge_cnt` = MID+2), so downstream timing is identical in both builds.

## Test plan
- Clean frame, PRESCALE=8, byte 0xA5 with even parity and stop bit, `smp_en` held for 88 cycles:
  - 11 `sample_vld` strobes, each 8 cycles apart, each at `edge_cnt`=6.
  - `sampled_bit` sequence 0,1,0,1,0,0,1,0,1,0,1 (start, LSB first, parity, stop).
  - One `frame_done`.
- Glitch rejection, PRESCALE=16, `RX_IN`=1 except a one-cycle low at `edge_cnt`=8:
  - With the macro, `sampled_bit`=1.
  - Without the macro, `sampled_bit`=0.
- Sample-window boundaries, PRESCALE=32, `RX_IN` low only at `edge_cnt` 15 and 17:
  - Majority gives `sampled_bit`=0.
  - Low at `edge_cnt` 14 and 18 only gives `sampled_bit`=1.
- Abort, PRESCALE=8, `smp_en` dropped at `bit_cnt`=3, `edge_cnt`=5:
  - Next cycle `edge_cnt`=0 and `bit_cnt`=0.
  - No `sample_vld` and no `frame_done`.
  - `sampled_bit` holds its last value.
- Reset mid-frame, `RST` pulsed for 1 cycle at `bit_cnt`=7: all outputs return to reset values on the next edge, with `sampled_bit`=1.
- Back-to-back frames, PRESCALE=16, `smp_en` held for 2×176 cycles: `frame_done` at cycles 176 and 352, and `bit_cnt` wraps 10→0 with no missed strobe.
